getir_tamponu: RTL and testbench

GETIR_TAMPONU -- requirements
Module: getir_tamponu

---
 rtl/getir_tamponu.sv | 135 +++++++++++++
 tb/tb_getir_tamponu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/getir_tamponu.sv
`default_nettype none
// ============================================================================
//  Module   : getir_tamponu
//  Purpose  : Fetch buffer between the instruction fetch stage and decode.
//             A small circular FIFO of DERINLIK entries.  Each entry holds
//             a fetched instruction word, its PC and the fetch fault flag,
//             which is 65 bits in total.  When the buffer is empty, decode
//             sees a NOP with PC 0 and no fault.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DERINLIK          number of entries (power of two, 2..16)
//    NOP_BUYRUK        instruction word presented while empty
//  Ports
//    clk_i             clock, rising edge
//    rst_ni            synchronous active-low reset
//    bosalt_i          flush (branch / exception redirect)
//    getir_gecerli_i   fetch entry valid
//    getir_hazir_o     buffer can accept an entry
//    getir_buyruk_i    fetched instruction word
//    getir_ps_i        PC of the fetched instruction
//    getir_hata_i      instruction access fault on this fetch
//    coz_gecerli_o     head entry valid toward decode
//    coz_hazir_i       decode accepts the head entry
//    coz_buyruk_o      head instruction word
//    coz_ps_o          head PC
//    coz_getir_hata_o  head fetch fault
//    doluluk_o         current occupancy
// ============================================================================
module getir_tamponu #(
  parameter int          DERINLIK   = 4,
  parameter logic [31:0] NOP_BUYRUK = 32'h0000_0013
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        bosalt_i,
  input  logic                        getir_gecerli_i,
  output logic                        getir_hazir_o,
  input  logic [31:0]                 getir_buyruk_i,
  input  logic [31:0]                 getir_ps_i,
  input  logic                        getir_hata_i,
  output logic                        coz_gecerli_o,
  input  logic                        coz_hazir_i,
  output logic [31:0]                 coz_buyruk_o,
  output logic [31:0]                 coz_ps_o,
  output logic                        coz_getir_hata_o,
  output logic [$clog2(DERINLIK):0]   doluluk_o
);

  localparam int c_PTR_W = $clog2(DERINLIK);
  localparam int c_DOL_W = c_PTR_W + 1;

  localparam logic [c_PTR_W-1:0] c_PTR_BIR     = c_PTR_W'(1);
  localparam logic [c_DOL_W-1:0] c_DOL_BIR     = c_DOL_W'(1);
  localparam logic [c_DOL_W-1:0] c_DOL_SIFIR   = '0;
  localparam logic [c_DOL_W-1:0] c_DOL_DERINLIK = c_DOL_W'(DERINLIK);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_PTR_W-1:0] r_yaz_ptr;
  logic [c_PTR_W-1:0] r_oku_ptr;
  logic [c_DOL_W-1:0] r_doluluk;

  // Entry layout: {fault, pc[31:0], instr[31:0]}
  logic [64:0] r_kayit [DERINLIK];

  logic        w_hazir;
  logic        w_gecerli;
  logic        w_yaz;
  logic        w_oku;
  logic [64:0] w_bas;

  // Both handshake qualifiers come from registered occupancy only, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign w_hazir   = (r_doluluk < c_DOL_DERINLIK);
  assign w_gecerli = (r_doluluk != c_DOL_SIFIR);

  // A flush cancels any handshake that happens in the same cycle.
  assign w_yaz = getir_gecerli_i && w_hazir   && !bosalt_i;
  assign w_oku = w_gecerli       && coz_hazir_i && !bosalt_i;

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // DERINLIK is a power of two, so the natural pointer overflow gives the
  // modulo-DERINLIK wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_doluluk <= '0;
    end else if (bosalt_i) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_doluluk <= '0;
    end else begin
      if (w_yaz) begin
        r_yaz_ptr <= r_yaz_ptr + c_PTR_BIR;
      end
      if (w_oku) begin
        r_oku_ptr <= r_oku_ptr + c_PTR_BIR;
      end
      case ({w_yaz, w_oku})
        2'b10:   r_doluluk <= r_doluluk + c_DOL_BIR;
        2'b01:   r_doluluk <= r_doluluk - c_DOL_BIR;
        default: r_doluluk <= r_doluluk;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. Not reset: stale contents are never visible because the
  // head outputs are masked whenever occupancy is zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_yaz) begin
      r_kayit[r_yaz_ptr] <= {getir_hata_i, getir_ps_i, getir_buyruk_i};
    end
  end

  assign w_bas = r_kayit[r_oku_ptr];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign getir_hazir_o    = w_hazir;
  assign coz_gecerli_o    = w_gecerli;
  assign coz_buyruk_o     = w_gecerli ? w_bas[31:0]  : NOP_BUYRUK;
  assign coz_ps_o         = w_gecerli ? w_bas[63:32] : 32'h0;
  assign coz_getir_hata_o = w_gecerli ? w_bas[64]    : 1'b0;
  assign doluluk_o        = r_doluluk;

endmodule
`default_nettype wire

// File: tb/tb_getir_tamponu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_getir_tamponu
//  Purpose  : Directed self-checking bench for getir_tamponu (DERINLIK = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_getir_tamponu;

  logic        clk_i;
  logic        rst_ni;
  logic        bosalt_i;
  logic        getir_gecerli_i;
  logic        getir_hazir_o;
  logic [31:0] getir_buyruk_i;
  logic [31:0] getir_ps_i;
  logic        getir_hata_i;
  logic        coz_gecerli_o;
  logic        coz_hazir_i;
  logic [31:0] coz_buyruk_o;
  logic [31:0] coz_ps_o;
  logic        coz_getir_hata_o;
  logic [2:0]  doluluk_o;

  int n_asrt;
  int n_fail;

  getir_tamponu #(
    .DERINLIK   (4),
    .NOP_BUYRUK (32'h0000_0013)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .bosalt_i         (bosalt_i),
    .getir_gecerli_i  (getir_gecerli_i),
    .getir_hazir_o    (getir_hazir_o),
    .getir_buyruk_i   (getir_buyruk_i),
    .getir_ps_i       (getir_ps_i),
    .getir_hata_i     (getir_hata_i),
    .coz_gecerli_o    (coz_gecerli_o),
    .coz_hazir_i      (coz_hazir_i),
    .coz_buyruk_o     (coz_buyruk_o),
    .coz_ps_o         (coz_ps_o),
    .coz_getir_hata_o (coz_getir_hata_o),
    .doluluk_o        (doluluk_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_doluluk"}, 32'(doluluk_o),        32'd0);
    chk({tag, "_hazir"},   32'(getir_hazir_o),    32'd1);
    chk({tag, "_gecerli"}, 32'(coz_gecerli_o),    32'd0);
    chk({tag, "_buyruk"},  coz_buyruk_o,          32'h0000_0013);
    chk({tag, "_ps"},      coz_ps_o,              32'h0);
    chk({tag, "_hata"},    32'(coz_getir_hata_o), 32'd0);
  endtask

  task automatic set_push(input logic v, input logic [31:0] ps, input logic [31:0] ins, input logic h);
    getir_gecerli_i = v;
    getir_ps_i      = ps;
    getir_buyruk_i  = ins;
    getir_hata_i    = h;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst_ni = 1'b0;
    bosalt_i = 1'b0;
    coz_hazir_i = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 1'b0);

    // ---- reset ----
    tick();
    tick();
    rst_ni = 1'b1;
    chk_reset_vals("reset");

    // ---- single push, visible only from the next cycle ----
    set_push(1'b1, 32'h1000, 32'h0050_0093, 1'b0);
    chk("push_no_bypass", 32'(coz_gecerli_o), 32'd0);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("push_gecerli", 32'(coz_gecerli_o), 32'd1);
    chk("push_buyruk",  coz_buyruk_o,        32'h0050_0093);
    chk("push_ps",      coz_ps_o,            32'h1000);
    chk("push_doluluk", 32'(doluluk_o),      32'd1);
    coz_hazir_i = 1'b1;
    tick();
    coz_hazir_i = 1'b0;
    chk("pop_doluluk", 32'(doluluk_o),  32'd0);
    chk("pop_nop",     coz_buyruk_o,    32'h0000_0013);

    // ---- fill and wrap ----
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'(4 * i), 32'hA000_0000 | 32'(4 * i), 1'b0);
      tick();
    end
    chk("full_hazir",    32'(getir_hazir_o), 32'd0);
    chk("full_doluluk",  32'(doluluk_o),     32'd4);
    set_push(1'b1, 32'h99, 32'hBAD0_0099, 1'b0);
    tick();
    chk("full_ignored",  32'(doluluk_o),     32'd4);
    chk("full_head_ps",  coz_ps_o,           32'h0);
    chk("full_head_ins", coz_buyruk_o,       32'hA000_0000);
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    coz_hazir_i = 1'b1;
    tick();
    tick();
    coz_hazir_i = 1'b0;
    chk("wrap_mid_ps",   coz_ps_o,           32'h8);
    chk("wrap_mid_dol",  32'(doluluk_o),     32'd2);
    set_push(1'b1, 32'h10, 32'hA000_0010, 1'b0);
    tick();
    set_push(1'b1, 32'h14, 32'hA000_0014, 1'b0);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_refill",   32'(doluluk_o),     32'd4);
    coz_hazir_i = 1'b1;
    chk("wrap_pop0", coz_ps_o, 32'h8);
    tick();
    chk("wrap_pop1", coz_ps_o, 32'hC);
    tick();
    chk("wrap_pop2", coz_ps_o, 32'h10);
    chk("wrap_pop2_ins", coz_buyruk_o, 32'hA000_0010);
    tick();
    chk("wrap_pop3", coz_ps_o, 32'h14);
    tick();
    coz_hazir_i = 1'b0;
    chk("wrap_empty", 32'(doluluk_o), 32'd0);

    // ---- simultaneous push and pop at occupancy 2 ----
    set_push(1'b1, 32'h100, 32'hC000_0100, 1'b0);
    tick();
    set_push(1'b1, 32'h104, 32'hC000_0104, 1'b0);
    tick();
    chk("sim_start_dol", 32'(doluluk_o), 32'd2);
    coz_hazir_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_push(1'b1, 32'h108 + 32'(4 * k), 32'hC000_0108 + 32'(4 * k), 1'b0);
      chk($sformatf("sim_head%0d", k), coz_ps_o, 32'h100 + 32'(4 * k));
      tick();
      chk($sformatf("sim_dol%0d", k), 32'(doluluk_o), 32'd2);
    end
    coz_hazir_i = 1'b0;
    chk("sim_end_head", coz_ps_o, 32'h128);

    // ---- flush at occupancy 3 with push and pop attempted ----
    set_push(1'b1, 32'h130, 32'hC000_0130, 1'b0);
    tick();
    chk("flush_pre_dol", 32'(doluluk_o), 32'd3);
    bosalt_i = 1'b1;
    coz_hazir_i = 1'b1;
    set_push(1'b1, 32'h134, 32'hC000_0134, 1'b0);
    chk("flush_cycle_gecerli", 32'(coz_gecerli_o), 32'd1);
    tick();
    bosalt_i = 1'b0;
    coz_hazir_i = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_doluluk", 32'(doluluk_o),     32'd0);
    chk("flush_gecerli", 32'(coz_gecerli_o), 32'd0);
    chk("flush_buyruk",  coz_buyruk_o,       32'h0000_0013);
    chk("flush_hazir",   32'(getir_hazir_o), 32'd1);

    // ---- fault passthrough ----
    set_push(1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b1);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("hata_flag",   32'(coz_getir_hata_o), 32'd1);
    chk("hata_ps",     coz_ps_o,              32'h2000);
    chk("hata_buyruk", coz_buyruk_o,          32'hDEAD_BEEF);
    coz_hazir_i = 1'b1;
    tick();
    coz_hazir_i = 1'b0;
    chk("hata_cleared", 32'(coz_getir_hata_o), 32'd0);

    // ---- reset mid-stream at occupancy 2 ----
    set_push(1'b1, 32'h3000, 32'hE000_3000, 1'b0);
    tick();
    set_push(1'b1, 32'h3004, 32'hE000_3004, 1'b0);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_mid_pre", 32'(doluluk_o), 32'd2);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk_reset_vals("rst_mid");
    set_push(1'b1, 32'h4000, 32'hF000_4000, 1'b0);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_post_gecerli", 32'(coz_gecerli_o), 32'd1);
    chk("rst_post_ps",      coz_ps_o,           32'h4000);
    chk("rst_post_dol",     32'(doluluk_o),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
